// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, programmable almost-empty/full
// thresholds, registered read data with valid strobe and sticky overflow/underflow flags.
module fifo_param #(
    parameter int RAM_WIDTH = 10,
    parameter int RAM_DEPTH = 8,
    parameter int PTR_SIZE  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_enb,
    input  logic                 rd_enb,
    input  logic [RAM_WIDTH-1:0] data_in,
    input  logic [PTR_SIZE:0]    alm_empty_thr,
    input  logic [PTR_SIZE:0]    alm_full_thr,
    output logic [RAM_WIDTH-1:0] data_out,
    output logic                 valid,
    output logic                 empty,
    output logic                 full,
    output logic                 alm_empty,
    output logic                 alm_full,
    output logic [PTR_SIZE:0]    count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [PTR_SIZE:0] DEPTH_CNT = (PTR_SIZE + 1)'(RAM_DEPTH);

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
    logic [PTR_SIZE:0]    wr_ptr;
    logic [PTR_SIZE:0]    rd_ptr;
    logic                 rd_acc;
    logic                 wr_acc;

    // Extra wrap bit lets the plain difference distinguish full from empty.
    assign count     = wr_ptr - rd_ptr;
    assign empty     = (count == '0);
    assign full      = (count == DEPTH_CNT);
    assign alm_empty = !empty && (count <= alm_empty_thr);
    assign alm_full  = (count >= alm_full_thr);

    // A pop frees a slot in the same cycle, so a push at full is accepted alongside it.
    assign rd_acc = rd_enb && !empty;
    assign wr_acc = wr_enb && (!full || rd_acc);

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[PTR_SIZE-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            valid <= rd_acc;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                data_out <= mem[rd_ptr[PTR_SIZE-1:0]];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            if (wr_enb && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (rd_enb && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_param.sv
// Directed self-checking bench for fifo_param at default 10x8 geometry.
module tb_fifo_param;

    localparam int W = 10;
    localparam int P = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_enb = 1'b0;
    logic         rd_enb = 1'b0;
    logic [W-1:0] data_in = '0;
    logic [P:0]   alm_empty_thr = 4'd2;
    logic [P:0]   alm_full_thr = 4'd6;
    logic [W-1:0] data_out;
    logic         valid, empty, full, alm_empty, alm_full, overflow, underflow;
    logic [P:0]   count;

    int tests_run = 0;
    int fails = 0;

    fifo_param #(.RAM_WIDTH(W), .RAM_DEPTH(8), .PTR_SIZE(P)) dut (
        .clk(clk), .rst(rst), .wr_enb(wr_enb), .rd_enb(rd_enb), .data_in(data_in),
        .alm_empty_thr(alm_empty_thr), .alm_full_thr(alm_full_thr),
        .data_out(data_out), .valid(valid), .empty(empty), .full(full),
        .alm_empty(alm_empty), .alm_full(alm_full), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [W-1:0] v;
        rst = 1'b1;
        tick();
        tick();
        tests_run++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
        tests_run++; if ({empty, full, alm_empty, alm_full} !== 4'b1000) begin fails++; $display("FAIL reset_flags got %b exp 1000", {empty, full, alm_empty, alm_full}); end
        tests_run++; if ({valid, overflow, underflow} !== 3'b000) begin fails++; $display("FAIL reset_status got %b exp 000", {valid, overflow, underflow}); end
        tests_run++; if (data_out !== 10'h000) begin fails++; $display("FAIL reset_data got %h exp 000", data_out); end
        rst = 1'b0;
        tick();
        // Push 4, pop 1: leaves 3 stored and a live valid/data_out, then force a rejected push
        for (int i = 0; i < 4; i++) begin
            v = 10'(10'h0A0 + i);
            wr_enb = 1'b1; data_in = v;
            tick();
        end
        wr_enb = 1'b0; rd_enb = 1'b1;
        tick();
        rd_enb = 1'b0;
        tests_run++; if ({count, valid, data_out} !== {4'd3, 1'b1, 10'h0A0}) begin fails++; $display("FAIL pre_async got cnt=%0d v=%b d=%h exp cnt=3 v=1 d=0a0", count, valid, data_out); end
        rd_enb = 1'b1;
        tick();
        tick();
        tick();
        tick();
        rd_enb = 1'b0;
        tests_run++; if (underflow !== 1'b1) begin fails++; $display("FAIL pre_async_udf got %b exp 1", underflow); end
        for (int i = 0; i < 3; i++) begin
            wr_enb = 1'b1; data_in = 10'(10'h0B0 + i);
            tick();
        end
        wr_enb = 1'b0; rd_enb = 1'b1;
        tick();
        rd_enb = 1'b0; wr_enb = 1'b1; data_in = 10'h0C0;
        tick();
        wr_enb = 1'b0;
        tests_run++; if ({count, valid, data_out, underflow} !== {4'd3, 1'b0, 10'h0B0, 1'b1}) begin fails++; $display("FAIL pre_async2 got cnt=%0d v=%b d=%h u=%b exp 3 0 0b0 1", count, valid, data_out, underflow); end
        rd_enb = 1'b1;
        tick();
        rd_enb = 1'b0;
        wr_enb = 1'b1; data_in = 10'h0C1;
        tick();
        wr_enb = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        tests_run++; if ({count, empty, full} !== {4'd0, 1'b1, 1'b0}) begin fails++; $display("FAIL async_rst_flags got cnt=%0d e=%b f=%b exp 0 1 0", count, empty, full); end
        tests_run++; if ({valid, overflow, underflow, data_out} !== {3'b000, 10'h000}) begin fails++; $display("FAIL async_rst_out got v=%b o=%b u=%b d=%h exp 0 0 0 000", valid, overflow, underflow, data_out); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        for (int unsigned i = 1; i <= 8; i++) begin
            wr_enb = 1'b1; data_in = 10'(i);
            tick();
            tests_run++; if (count !== 4'(i)) begin fails++; $display("FAIL fill_count got %0d exp %0d", count, i); end
            tests_run++; if ({empty, alm_empty, alm_full, full} !== {1'b0, i <= 2, i >= 6, i == 8}) begin fails++; $display("FAIL fill_flags@%0d got %b exp %b", i, {empty, alm_empty, alm_full, full}, {1'b0, i <= 2, i >= 6, i == 8}); end
        end
        wr_enb = 1'b0;
    endtask

    task automatic test_overflow_drain();
        wr_enb = 1'b1; data_in = 10'h3FF;
        tick();
        wr_enb = 1'b0;
        tests_run++; if ({count, full, overflow} !== {4'd8, 1'b1, 1'b1}) begin fails++; $display("FAIL overflow got cnt=%0d f=%b o=%b exp 8 1 1", count, full, overflow); end
        for (int unsigned i = 1; i <= 8; i++) begin
            rd_enb = 1'b1;
            tick();
            tests_run++; if ({valid, data_out} !== {1'b1, 10'(i)}) begin fails++; $display("FAIL drain@%0d got v=%b d=%h exp v=1 d=%h", i, valid, data_out, 10'(i)); end
        end
        rd_enb = 1'b0;
        tests_run++; if ({empty, count, underflow} !== {1'b1, 4'd0, 1'b0}) begin fails++; $display("FAIL drain_end got e=%b cnt=%0d u=%b exp 1 0 0", empty, count, underflow); end
        tick();
        tests_run++; if ({valid, data_out} !== {1'b0, 10'h008}) begin fails++; $display("FAIL idle_hold got v=%b d=%h exp 0 008", valid, data_out); end
    endtask

    task automatic test_simul_empty();
        wr_enb = 1'b1; rd_enb = 1'b1; data_in = 10'h055;
        tick();
        wr_enb = 1'b0; rd_enb = 1'b0;
        tests_run++; if ({count, valid, underflow} !== {4'd1, 1'b0, 1'b1}) begin fails++; $display("FAIL simul_empty got cnt=%0d v=%b u=%b exp 1 0 1", count, valid, underflow); end
        rd_enb = 1'b1;
        tick();
        rd_enb = 1'b0;
        tests_run++; if ({valid, data_out, count} !== {1'b1, 10'h055, 4'd0}) begin fails++; $display("FAIL simul_empty_pop got v=%b d=%h cnt=%0d exp 1 055 0", valid, data_out, count); end
    endtask

    task automatic test_simul_full();
        for (int i = 0; i < 8; i++) begin
            wr_enb = 1'b1; data_in = 10'(10'h010 + i);
            tick();
        end
        wr_enb = 1'b1; rd_enb = 1'b1; data_in = 10'h0AA;
        tick();
        wr_enb = 1'b0;
        tests_run++; if ({count, full, valid, data_out} !== {4'd8, 1'b1, 1'b1, 10'h010}) begin fails++; $display("FAIL simul_full got cnt=%0d f=%b v=%b d=%h exp 8 1 1 010", count, full, valid, data_out); end
        for (int i = 1; i <= 7; i++) begin
            tick();
            tests_run++; if (data_out !== 10'(10'h010 + i)) begin fails++; $display("FAIL simul_full_pop%0d got %h exp %h", i, data_out, 10'(10'h010 + i)); end
        end
        tick();
        rd_enb = 1'b0;
        tests_run++; if ({valid, data_out, empty} !== {1'b1, 10'h0AA, 1'b1}) begin fails++; $display("FAIL simul_full_last got v=%b d=%h e=%b exp 1 0aa 1", valid, data_out, empty); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] q[$];
        logic [W-1:0] nxt;
        logic [W-1:0] exp_d;
        int unsigned  mode;
        int           errs;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nxt = 10'h100;
        for (int i = 0; i < 4; i++) begin
            wr_enb = 1'b1; data_in = nxt; q.push_back(nxt); nxt++;
            tick();
        end
        wr_enb = 1'b0;
        errs = 0;
        for (int n = 0; n < 100; n++) begin
            repeat ($urandom_range(0, 2)) tick();
            mode = $urandom_range(0, 2);
            if (mode == 0) begin
                wr_enb = 1'b1; rd_enb = 1'b1; data_in = nxt;
                exp_d = q.pop_front(); q.push_back(nxt); nxt++;
                tick();
                wr_enb = 1'b0; rd_enb = 1'b0;
                if (data_out !== exp_d || valid !== 1'b1 || count !== 4'd4) begin errs++; $display("FAIL stream_pair@%0d got d=%h v=%b cnt=%0d exp d=%h v=1 cnt=4", n, data_out, valid, count, exp_d); end
            end else if (mode == 1) begin
                wr_enb = 1'b1; data_in = nxt; q.push_back(nxt); nxt++;
                tick();
                wr_enb = 1'b0;
                if (count !== 4'd5) begin errs++; $display("FAIL stream_push@%0d got cnt=%0d exp 5", n, count); end
                rd_enb = 1'b1; exp_d = q.pop_front();
                tick();
                rd_enb = 1'b0;
                if (data_out !== exp_d || count !== 4'd4) begin errs++; $display("FAIL stream_pop@%0d got d=%h cnt=%0d exp d=%h cnt=4", n, data_out, count, exp_d); end
            end else begin
                rd_enb = 1'b1; exp_d = q.pop_front();
                tick();
                rd_enb = 1'b0;
                if (data_out !== exp_d || count !== 4'd3) begin errs++; $display("FAIL stream_pop3@%0d got d=%h cnt=%0d exp d=%h cnt=3", n, data_out, count, exp_d); end
                wr_enb = 1'b1; data_in = nxt; q.push_back(nxt); nxt++;
                tick();
                wr_enb = 1'b0;
                if (count !== 4'd4) begin errs++; $display("FAIL stream_push3@%0d got cnt=%0d exp 4", n, count); end
            end
        end
        tests_run++; if (errs != 0) begin fails++; $display("FAIL stream_order got %0d errors exp 0", errs); end
        for (int i = 0; i < 4; i++) begin
            rd_enb = 1'b1; exp_d = q.pop_front();
            tick();
            tests_run++; if (data_out !== exp_d) begin fails++; $display("FAIL stream_drain%0d got %h exp %h", i, data_out, exp_d); end
        end
        rd_enb = 1'b0;
        tests_run++; if ({empty, overflow, underflow} !== 3'b100) begin fails++; $display("FAIL stream_end got e=%b o=%b u=%b exp 1 0 0", empty, overflow, underflow); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow_drain();
        test_simul_empty();
        test_simul_full();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
Parametrised synchronous FIFO, the next generation of the fixed 10x8 FIFO used between the ingress path and the arbiter. It adds generic width and depth, a true full flag, an occupancy count, and programmable almost-empty and almost-full thresholds. It also adds a read-valid strobe and sticky overflow/underflow error flags. The arbiter consumes the status flags; the downstream stage consumes data_out/valid.

Parameters:
RAM_WIDTH, 10, bits per entry
RAM_DEPTH, 8, number of entries; power of 2, >=2
PTR_SIZE, 3, log2(RAM_DEPTH); pointers are PTR_SIZE+1 bits internally (extra wrap bit)

Ports:
clk  in  1  single clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
wr_enb  in  1  push request
rd_enb  in  1  pop request
data_in  in  RAM_WIDTH  push data
alm_empty_thr  in  PTR_SIZE+1  almost-empty threshold, quasi-static
alm_full_thr  in  PTR_SIZE+1  almost-full threshold, quasi-static
data_out  out  RAM_WIDTH  registered pop data
valid  out  1  data_out updated by an accepted pop in the previous cycle
empty  out  1  count == 0
full  out  1  count == RAM_DEPTH
alm_empty  out  1  count != 0 and count <= alm_empty_thr
alm_full  out  1  count >= alm_full_thr
count  out  PTR_SIZE+1  current occupancy, 0..RAM_DEPTH
overflow  out  1  sticky: push requested while full and not accepted
underflow  out  1  sticky: pop requested while empty

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset, asserted asynchronously: wr_ptr=0, rd_ptr=0, data_out=0, valid=0, overflow=0, underflow=0.
- Resulting flags during reset: empty=1, full=0, alm_empty=0, alm_full=(alm_full_thr==0), count=0.
- Memory contents are not reset; with no valid data they are unobservable. Reset mid-operation discards all stored entries immediately.
- Internal pointers are PTR_SIZE+1 bits. Memory is indexed by the low PTR_SIZE bits.
- count = wr_ptr - rd_ptr, modulo 2^(PTR_SIZE+1).
- Wrap-around is natural binary rollover; no special handling.
- Status flags are combinational from the registered pointers and thresholds, so they reflect state after the last clock edge.
- Push accepted when wr_enb and (not full, or rd_enb accepted in the same cycle).
  - On accept: mem[wr_ptr] <= data_in; wr_ptr += 1.
- Pop accepted when rd_enb and not empty.
  - On accept: data_out <= mem[rd_ptr]; rd_ptr += 1; valid <= 1.
  - Otherwise valid <= 0 and data_out holds its value.
- Read latency: 1 cycle. Data appears on data_out with valid=1 on the edge after the pop request is sampled.
- Simultaneous push+pop:
  - When empty: push accepted, pop rejected. No write-through bypass; underflow sets; count becomes 1.
  - When full: both accepted; count stays RAM_DEPTH; the popped entry is the oldest.
  - Otherwise: both accepted; count unchanged.
- Rejected push (wr_enb & full & !rd_enb): memory and wr_ptr unchanged; overflow <= 1.
- Rejected pop (rd_enb & empty): rd_ptr unchanged; underflow <= 1.
- overflow and underflow stay at 1 until rst.
- Threshold handling:
  - Thresholds are compared unsigned at full PTR_SIZE+1 width.
  - alm_full_thr > RAM_DEPTH means alm_full never asserts.
  - alm_empty_thr = 0 means alm_empty never asserts.
- Defaults for the arbiter are alm_empty_thr=2 and alm_full_thr=6 (with RAM_DEPTH=8).
- Ordering is strict FIFO; no entry is lost or duplicated across any number of pointer wraps.

Test Plan:
1. Reset then idle -> empty=1, full=0, count=0, valid=0, data_out=0, overflow=underflow=0; drive rst high mid-cycle with 3 entries stored -> all of these outputs clear without waiting for a clk edge.
2. Thresholds 2/6; push 0x001..0x008 one per cycle -> count 1..8; alm_empty=1 at counts 1-2; alm_full=1 from count 6; full=1 at 8.
3. At full, push 0x3FF alone -> count stays 8, overflow=1. Pop 8 times -> data_out 0x001..0x008 in order, each with valid=1 one cycle after its rd_enb; empty=1 at the end.
4. Empty FIFO, wr_enb=rd_enb=1 with 0x055 -> count=1, valid=0 next cycle, underflow=1. The next pop returns 0x055.
5. Full FIFO, simultaneous push 0x0AA and pop -> count stays 8, data_out=oldest entry. The 0x0AA entry appears after 7 further pops.
6. Stream 100 push/pop pairs with random gaps while count stays in 3..5 (pointers wrap repeatedly) -> output sequence equals input sequence; overflow and underflow remain 0.
